branch_predictor_btb: RTL and testbench

//  Fetch-side predictor: direct-mapped BTB with 2-bit saturating counters.

---
 rtl/branch_predictor_btb_if.sv | 39 +++
 rtl/branch_predictor_btb.sv | 130 +++++++++++++
 tb/tb_branch_predictor_btb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Fetch/execute-side bundle for the branch predictor: lookup, training,
// redirect and performance counter signals.
interface branch_predictor_btb_if #(
    parameter int XLEN = 32
) ();
    logic            flush_btb;
    logic            lookup_valid;
    logic [XLEN-1:0] lookup_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_next_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;

    modport master (
        output flush_btb, lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_next_pc,
        input  mispredict, redirect_pc, perf_branches, perf_mispredicts
    );

    modport slave (
        input  flush_btb, lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_next_pc,
        output mispredict, redirect_pc, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters, same-cycle
// prediction, execute-stage training, mispredict detection and perf counters.
module branch_predictor_btb #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_btb_if.slave bp
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};

    logic             valid_r  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_r    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_r [BTB_ENTRIES];
    logic [1:0]       ctr_r    [BTB_ENTRIES];
    logic [31:0]      perf_branches_r;
    logic [31:0]      perf_mispredicts_r;

    logic [IDX-1:0]   lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             lk_hit_s;
    logic             lk_taken_s;
    logic [XLEN-1:0]  lk_next_pc_s;
    logic [IDX-1:0]   up_idx_s;
    logic [TAG_W-1:0] up_tag_s;
    logic             up_hit_s;
    logic             mispredict_s;
    logic [XLEN-1:0]  redirect_pc_s;

    // Saturating step of a 2-bit direction counter toward the resolved outcome.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

    // Fetch-side lookup: reads current (pre-update) table contents.
    always_comb begin
        lk_idx_s     = bp.lookup_pc[IDX+1:2];
        lk_tag_s     = bp.lookup_pc[XLEN-1:IDX+2];
        lk_hit_s     = bp.lookup_valid & valid_r[lk_idx_s] & (tag_r[lk_idx_s] == lk_tag_s);
        lk_taken_s   = lk_hit_s & ctr_r[lk_idx_s][1];
        lk_next_pc_s = bp.lookup_pc + PC_INC;
        if (lk_taken_s) begin
            lk_next_pc_s = target_r[lk_idx_s];
        end else begin
            lk_next_pc_s = bp.lookup_pc + PC_INC;
        end
    end

    // Resolution side: hit detection, mispredict and the correct next PC.
    always_comb begin
        up_idx_s      = bp.upd_pc[IDX+1:2];
        up_tag_s      = bp.upd_pc[XLEN-1:IDX+2];
        up_hit_s      = valid_r[up_idx_s] & (tag_r[up_idx_s] == up_tag_s);
        mispredict_s  = bp.upd_valid &
                        ((bp.upd_taken != bp.upd_pred_taken) |
                         (bp.upd_taken & (bp.upd_target != bp.upd_pred_target)));
        redirect_pc_s = bp.upd_pc + PC_INC;
        if (bp.upd_taken) begin
            redirect_pc_s = bp.upd_target;
        end else begin
            redirect_pc_s = bp.upd_pc + PC_INC;
        end
    end

    // Table training; reset beats flush, flush beats any allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
                ctr_r[i]    <= 2'b01;
            end
        end else if (bp.flush_btb) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (bp.upd_valid) begin
            if (up_hit_s) begin
                if (bp.upd_is_jump) begin
                    // Jumps are always taken; JALR may have moved its target.
                    ctr_r[up_idx_s]    <= 2'b11;
                    target_r[up_idx_s] <= bp.upd_target;
                end else begin
                    ctr_r[up_idx_s] <= ctr_step(ctr_r[up_idx_s], bp.upd_taken);
                    if (bp.upd_taken) begin
                        target_r[up_idx_s] <= bp.upd_target;
                    end
                end
            end else if (bp.upd_taken) begin
                valid_r[up_idx_s]  <= 1'b1;
                tag_r[up_idx_s]    <= up_tag_s;
                target_r[up_idx_s] <= bp.upd_target;
                ctr_r[up_idx_s]    <= bp.upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // Free-running perf counters; they wrap and still count across a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_r    <= 32'd0;
            perf_mispredicts_r <= 32'd0;
        end else begin
            if (bp.upd_valid) begin
                perf_branches_r <= perf_branches_r + 32'd1;
            end
            if (mispredict_s) begin
                perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
            end
        end
    end

    assign bp.pred_hit         = lk_hit_s;
    assign bp.pred_taken       = lk_taken_s;
    assign bp.pred_next_pc     = lk_next_pc_s;
    assign bp.mispredict       = mispredict_s;
    assign bp.redirect_pc      = redirect_pc_s;
    assign bp.perf_branches    = perf_branches_r;
    assign bp.perf_mispredicts = perf_mispredicts_r;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: behavioural BTB model checked every
// cycle, plus literal expectations at the interesting points.
module tb_branch_predictor_btb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_btb_if #(.XLEN(32)) bp ();
    branch_predictor_btb #(.XLEN(32), .BTB_ENTRIES(64)) dut (.clk(clk), .rst(rst), .bp(bp));

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    // Model: each slot remembers the full word address that owns it.
    bit          m_valid [64];
    logic [29:0] m_word  [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    logic [31:0] m_br, m_mp;

    logic        e_hit, e_taken, e_mp;
    logic [31:0] e_next, e_redir;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd64);
    endfunction

    function automatic logic exp_mispredict();
        return bp.upd_valid && ((bp.upd_taken != bp.upd_pred_taken) ||
               (bp.upd_taken && bp.upd_target != bp.upd_pred_target));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  s;
        bit  hit;
        logic mp;
        mp = exp_mispredict();
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_word[i]  = 30'd0;
                m_tgt[i]   = 32'd0;
                m_ctr[i]   = 1;
            end
            m_br = 32'd0;
            m_mp = 32'd0;
            return;
        end
        if (bp.upd_valid) m_br = m_br + 32'd1;
        if (mp) m_mp = m_mp + 32'd1;
        if (bp.flush_btb) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        end else if (bp.upd_valid) begin
            s   = slot(bp.upd_pc);
            hit = m_valid[s] && (m_word[s] == bp.upd_pc[31:2]);
            if (hit && bp.upd_is_jump) begin
                m_ctr[s] = 3;
                m_tgt[s] = bp.upd_target;
            end else if (hit) begin
                m_ctr[s] = bp.upd_taken ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                        : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                if (bp.upd_taken) m_tgt[s] = bp.upd_target;
            end else if (bp.upd_taken) begin
                m_valid[s] = 1'b1;
                m_word[s]  = bp.upd_pc[31:2];
                m_tgt[s]   = bp.upd_target;
                m_ctr[s]   = bp.upd_is_jump ? 3 : 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_lk(input logic v, input logic [31:0] pc);
        bp.lookup_valid = v;
        bp.lookup_pc    = pc;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic jmp, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bp.upd_valid       = 1'b1;
        bp.upd_pc          = pc;
        bp.upd_is_jump     = jmp;
        bp.upd_taken       = tk;
        bp.upd_target      = tgt;
        bp.upd_pred_taken  = ptk;
        bp.upd_pred_target = ptgt;
    endtask

    task automatic clr_upd();
        bp.upd_valid       = 1'b0;
        bp.upd_pc          = 32'd0;
        bp.upd_is_jump     = 1'b0;
        bp.upd_taken       = 1'b0;
        bp.upd_target      = 32'd0;
        bp.upd_pred_taken  = 1'b0;
        bp.upd_pred_target = 32'd0;
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always begin
        @(negedge clk);
        #2;
        if (started) begin
            int s;
            s       = slot(bp.lookup_pc);
            e_hit   = bp.lookup_valid && m_valid[s] && (m_word[s] == bp.lookup_pc[31:2]);
            e_taken = e_hit && (m_ctr[s] >= 2);
            e_next  = e_taken ? m_tgt[s] : bp.lookup_pc + 32'd4;
            e_mp    = exp_mispredict();
            e_redir = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
            chk("pred_hit", {31'd0, bp.pred_hit}, {31'd0, e_hit});
            chk("pred_taken", {31'd0, bp.pred_taken}, {31'd0, e_taken});
            chk("pred_next_pc", bp.pred_next_pc, e_next);
            chk("mispredict", {31'd0, bp.mispredict}, {31'd0, e_mp});
            if (e_mp) chk("redirect_pc", bp.redirect_pc, e_redir);
            chk("perf_branches", bp.perf_branches, m_br);
            chk("perf_mispredicts", bp.perf_mispredicts, m_mp);
        end
    end

    initial begin
        rst = 1'b1;
        bp.flush_btb = 1'b0;
        set_lk(1'b0, 32'd0);
        clr_upd();
        tick();
        tick();
        rst = 1'b0;
        started = 1'b1;

        // Cold miss
        set_lk(1'b1, 32'h100);
        #3 chk("cold_hit", {31'd0, bp.pred_hit}, 32'd0);
        chk("cold_next", bp.pred_next_pc, 32'h104);
        chk("rst_perf", bp.perf_branches, 32'd0);
        tick();

        // Allocate; same-cycle lookup sees pre-update state
        set_upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        #3 chk("alloc_mp", {31'd0, bp.mispredict}, 32'd1);
        chk("alloc_redir", bp.redirect_pc, 32'h80);
        chk("alloc_same_cycle_hit", {31'd0, bp.pred_hit}, 32'd0);
        tick();
        clr_upd();
        #3 chk("alloc_hit", {31'd0, bp.pred_hit}, 32'd1);
        chk("alloc_next", bp.pred_next_pc, 32'h80);
        tick();

        // Hysteresis: 10 -> 11 -> 10 -> 01
        set_upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        #3 chk("hyst_correct", {31'd0, bp.mispredict}, 32'd0);
        tick();
        set_upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        #3 chk("hyst_nt1_mp", {31'd0, bp.mispredict}, 32'd1);
        chk("hyst_nt1_redir", bp.redirect_pc, 32'h104);
        tick();
        #3 chk("hyst_still_taken", {31'd0, bp.pred_taken}, 32'd1);
        tick();
        clr_upd();
        #3 chk("hyst_now_nt", {31'd0, bp.pred_taken}, 32'd0);
        chk("hyst_next", bp.pred_next_pc, 32'h104);
        chk("hyst_perf_br", bp.perf_branches, 32'd4);
        chk("hyst_perf_mp", bp.perf_mispredicts, 32'd3);
        tick();

        // Alias on index 0
        set_upd(32'h200, 1'b0, 1'b1, 32'h500, 1'b0, 32'h204);
        tick();
        clr_upd();
        #3 chk("alias_old_miss", {31'd0, bp.pred_hit}, 32'd0);
        tick();
        set_lk(1'b1, 32'h200);
        #3 chk("alias_new_next", bp.pred_next_pc, 32'h500);
        tick();

        // JALR target change
        set_upd(32'h40, 1'b1, 1'b1, 32'h300, 1'b0, 32'h44);
        tick();
        clr_upd();
        set_lk(1'b1, 32'h40);
        #3 chk("jal_next", bp.pred_next_pc, 32'h300);
        tick();
        set_upd(32'h40, 1'b1, 1'b1, 32'h400, 1'b1, 32'h300);
        #3 chk("jalr_mp", {31'd0, bp.mispredict}, 32'd1);
        chk("jalr_redir", bp.redirect_pc, 32'h400);
        tick();
        clr_upd();
        #3 chk("jalr_new_next", bp.pred_next_pc, 32'h400);
        tick();

        // PC wrap and invalid lookup
        set_lk(1'b1, 32'hFFFF_FFFC);
        #3 chk("wrap_next", bp.pred_next_pc, 32'h0);
        tick();
        set_lk(1'b0, 32'h40);
        #3 chk("nolookup_hit", {31'd0, bp.pred_hit}, 32'd0);
        chk("nolookup_next", bp.pred_next_pc, 32'h44);
        tick();

        // Not-taken miss does not allocate
        set_upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h84);
        #3 chk("ntmiss_mp", {31'd0, bp.mispredict}, 32'd0);
        tick();
        clr_upd();
        set_lk(1'b1, 32'h80);
        #3 chk("ntmiss_hit", {31'd0, bp.pred_hit}, 32'd0);
        tick();

        // Flush and update in the same cycle
        bp.flush_btb = 1'b1;
        set_upd(32'h600, 1'b0, 1'b1, 32'h700, 1'b0, 32'h604);
        tick();
        bp.flush_btb = 1'b0;
        clr_upd();
        set_lk(1'b1, 32'h600);
        #3 chk("flush_no_alloc", {31'd0, bp.pred_hit}, 32'd0);
        tick();
        set_lk(1'b1, 32'h40);
        #3 chk("flush_cleared", {31'd0, bp.pred_hit}, 32'd0);
        tick();

        // Retrain, then reset during an update
        set_upd(32'h40, 1'b1, 1'b1, 32'h300, 1'b0, 32'h44);
        tick();
        clr_upd();
        #3 chk("retrain_hit", {31'd0, bp.pred_hit}, 32'd1);
        tick();
        rst = 1'b1;
        set_upd(32'hA00, 1'b1, 1'b1, 32'hB00, 1'b0, 32'hA04);
        tick();
        rst = 1'b0;
        clr_upd();
        set_lk(1'b1, 32'hA00);
        #3 chk("rst_no_alloc", {31'd0, bp.pred_hit}, 32'd0);
        chk("rst_perf_br", bp.perf_branches, 32'd0);
        chk("rst_perf_mp", bp.perf_mispredicts, 32'd0);
        tick();
        set_lk(1'b1, 32'h40);
        #3 chk("rst_cleared", {31'd0, bp.pred_hit}, 32'd0);
        tick();

        // Perf counter wrap from a preloaded all-ones value
        force dut.perf_branches_r = 32'hFFFF_FFFF;
        #1 release dut.perf_branches_r;
        m_br = 32'hFFFF_FFFF;
        set_upd(32'h900, 1'b0, 1'b0, 32'h0, 1'b0, 32'h904);
        #2 chk("preload", bp.perf_branches, 32'hFFFF_FFFF);
        tick();
        clr_upd();
        #3 chk("perf_wrap", bp.perf_branches, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
